// File: rtl/stack_sequencer.sv
// Stack sequencer for CALL/RET/INT/RTI: splits PC and flags into 16-bit stack
// accesses, one per cycle, owns the stack pointer and returns the resolved PC.
module stack_sequencer #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned FLAG_W   = 3,
   parameter logic [31:0] SP_RESET = 32'h0000_0FFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic [1:0]        req_op,
   input  logic [31:0]       req_pc,
   input  logic [31:0]       req_target,
   input  logic [FLAG_W-1:0] req_flags,
   output logic              req_ready,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata,
   output logic [ADDR_W-1:0] sp,
   output logic [1:0]        count_out,
   output logic              done,
   output logic [31:0]       pc_out,
   output logic [FLAG_W-1:0] flags_out,
   output logic              flags_load
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned PC_W   = 32;
   localparam int unsigned CNT_W  = 2;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DRAIN, S_DONE} state_e;
   typedef enum logic [1:0] {OP_CALL, OP_RET, OP_INT, OP_RTI} op_e;

   state_e              state, state_n;
   op_e                 op_q, op_n;
   logic [PC_W-1:0]     pc_q, pc_n;
   logic [PC_W-1:0]     target_q, target_n;
   logic [FLAG_W-1:0]   flags_q, flags_n;
   logic [CNT_W-1:0]    count_q, count_n;
   logic [ADDR_W-1:0]   sp_q, sp_n;
   logic [PC_W-1:0]     rd_pc_q, rd_pc_n;
   logic [FLAG_W-1:0]   rd_flags_q, rd_flags_n;
   logic                rd_pend_q, rd_pend_n;
   logic [CNT_W-1:0]    rd_idx_q, rd_idx_n;

   logic                req_ready_n, busy_n, mem_en_n, mem_we_n, done_n, flags_load_n;
   logic [ADDR_W-1:0]   mem_addr_n;
   logic [DATA_W-1:0]   mem_wdata_n;
   logic [PC_W-1:0]     pc_out_n;
   logic [FLAG_W-1:0]   flags_out_n;

   function automatic logic is_push(input op_e op);
      return (op == OP_CALL) || (op == OP_INT);
   endfunction

   function automatic logic [CNT_W-1:0] n_access(input op_e op);
      return ((op == OP_CALL) || (op == OP_RET)) ? CNT_W'(2) : CNT_W'(3);
   endfunction

   assign sp        = sp_q;
   assign count_out = count_q;

   // Next-state, datapath and next-output computation; outputs are registered
   // from the next-cycle values so they line up with the state they describe.
   always_comb begin
      state_n    = state;
      op_n       = op_q;
      pc_n       = pc_q;
      target_n   = target_q;
      flags_n    = flags_q;
      count_n    = count_q;
      sp_n       = sp_q;
      rd_pc_n    = rd_pc_q;
      rd_flags_n = rd_flags_q;
      rd_pend_n  = 1'b0;
      rd_idx_n   = rd_idx_q;

      // Read data arrives one cycle after its access; slot selects the field.
      if (rd_pend_q) begin
         case (rd_idx_q)
            CNT_W'(0): rd_pc_n[15:0]  = mem_rdata;
            CNT_W'(1): rd_pc_n[31:16] = mem_rdata;
            default:   rd_flags_n     = mem_rdata[FLAG_W-1:0];
         endcase
      end

      case (state)
         S_IDLE: begin
            if (req_valid) begin
               op_n       = op_e'(req_op);
               pc_n       = req_pc;
               target_n   = req_target;
               flags_n    = req_flags;
               count_n    = n_access(op_e'(req_op));
               rd_pc_n    = '0;
               rd_flags_n = '0;
               state_n    = S_ACCESS;
            end
         end
         S_ACCESS: begin
            count_n = count_q - CNT_W'(1);
            if (is_push(op_q)) begin
               sp_n = sp_q - ADDR_W'(1);
            end else begin
               sp_n      = sp_q + ADDR_W'(1);
               rd_pend_n = 1'b1;
               rd_idx_n  = n_access(op_q) - count_q;
            end
            if (count_q == CNT_W'(1)) state_n = S_DRAIN;
         end
         S_DRAIN: state_n = S_DONE;
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase

      req_ready_n  = (state_n == S_IDLE);
      busy_n       = !req_ready_n;
      mem_en_n     = (state_n == S_ACCESS);
      mem_we_n     = mem_en_n && is_push(op_n);
      mem_addr_n   = (mem_en_n && !is_push(op_n)) ? sp_n + ADDR_W'(1) : sp_n;
      mem_wdata_n  = '0;
      if (mem_we_n) begin
         case (count_n)
            CNT_W'(3): mem_wdata_n = DATA_W'(flags_n);
            CNT_W'(2): mem_wdata_n = pc_n[31:16];
            default:   mem_wdata_n = pc_n[15:0];
         endcase
      end
      done_n       = (state_n == S_DONE);
      pc_out_n     = '0;
      if (done_n) pc_out_n = is_push(op_n) ? target_n : rd_pc_n;
      flags_load_n = done_n && (op_n == OP_RTI);
      flags_out_n  = flags_load_n ? rd_flags_n : '0;
   end

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         op_q       <= OP_CALL;
         pc_q       <= '0;
         target_q   <= '0;
         flags_q    <= '0;
         count_q    <= '0;
         sp_q       <= ADDR_W'(SP_RESET);
         rd_pc_q    <= '0;
         rd_flags_q <= '0;
         rd_pend_q  <= 1'b0;
         rd_idx_q   <= '0;
         req_ready  <= 1'b1;
         busy       <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= ADDR_W'(SP_RESET);
         mem_wdata  <= '0;
         done       <= 1'b0;
         pc_out     <= '0;
         flags_out  <= '0;
         flags_load <= 1'b0;
      end else begin
         state      <= state_n;
         op_q       <= op_n;
         pc_q       <= pc_n;
         target_q   <= target_n;
         flags_q    <= flags_n;
         count_q    <= count_n;
         sp_q       <= sp_n;
         rd_pc_q    <= rd_pc_n;
         rd_flags_q <= rd_flags_n;
         rd_pend_q  <= rd_pend_n;
         rd_idx_q   <= rd_idx_n;
         req_ready  <= req_ready_n;
         busy       <= busy_n;
         mem_en     <= mem_en_n;
         mem_we     <= mem_we_n;
         mem_addr   <= mem_addr_n;
         mem_wdata  <= mem_wdata_n;
         done       <= done_n;
         pc_out     <= pc_out_n;
         flags_out  <= flags_out_n;
         flags_load <= flags_load_n;
      end
   end

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed, table-driven bench for stack_sequencer with a small stack memory
// model; a second instance exercises a zero reset stack pointer.
module tb_stack_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        req_valid, req_ready, busy, mem_en, mem_we, done, flags_load;
   logic [1:0]  req_op, count_out;
   logic [31:0] req_pc, req_target, mem_addr, sp, pc_out;
   logic [2:0]  req_flags, flags_out;
   logic [15:0] mem_wdata, mem_rdata;

   logic        req_valid1, req_ready1, busy1, mem_en1, mem_we1, done1, flags_load1;
   logic [1:0]  req_op1, count_out1;
   logic [31:0] req_pc1, req_target1, mem_addr1, sp1, pc_out1;
   logic [2:0]  req_flags1, flags_out1;
   logic [15:0] mem_wdata1;

   int pass_cnt = 0;
   int total_cnt = 0;
   int done_cnt = 0;
   int done1_cnt = 0;

   always #5 clk = ~clk;

   stack_sequencer dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_pc(req_pc),
      .req_target(req_target), .req_flags(req_flags), .req_ready(req_ready), .busy(busy),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .sp(sp), .count_out(count_out), .done(done), .pc_out(pc_out),
      .flags_out(flags_out), .flags_load(flags_load)
   );

   stack_sequencer #(.SP_RESET(32'h0)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_op(req_op1), .req_pc(req_pc1),
      .req_target(req_target1), .req_flags(req_flags1), .req_ready(req_ready1), .busy(busy1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_rdata(16'h0), .sp(sp1), .count_out(count_out1), .done(done1), .pc_out(pc_out1),
      .flags_out(flags_out1), .flags_load(flags_load1)
   );

   // Stack memory: writes land at the edge, read data shows up the next cycle.
   logic [15:0] mem [logic [31:0]];
   initial mem_rdata = 16'h0;
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] = mem_wdata;
         else mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 16'h0;
      end
   end

   always @(posedge clk) begin
      if (done)  done_cnt  <= done_cnt + 1;
      if (done1) done1_cnt <= done1_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] pc;
      logic [31:0] target;
      logic [2:0]  flags;
      int          n;
      logic [31:0] a0, a1, a2;
      logic [15:0] w0, w1, w2;
      logic [31:0] exp_pc;
      logic        exp_fload;
      logic [2:0]  exp_flags;
      logic [31:0] exp_sp;
   } vec_t;

   vec_t vecs[6];

   initial begin
      // op, pc, target, flags, n, addrs, write data, pc_out, flags_load, flags_out, sp after
      vecs[0] = '{2'b00, 32'h0001_2345, 32'h0000_0100, 3'b000, 2, 32'hFFF, 32'hFFE, 32'h0,
                  16'h0001, 16'h2345, 16'h0, 32'h0000_0100, 1'b0, 3'b000, 32'hFFD};
      vecs[1] = '{2'b01, 32'h0, 32'h0, 3'b000, 2, 32'hFFE, 32'hFFF, 32'h0,
                  16'h0, 16'h0, 16'h0, 32'h0001_2345, 1'b0, 3'b000, 32'hFFF};
      vecs[2] = '{2'b10, 32'h0000_ABCD, 32'h0000_0200, 3'b101, 3, 32'hFFF, 32'hFFE, 32'hFFD,
                  16'h0005, 16'h0000, 16'hABCD, 32'h0000_0200, 1'b0, 3'b000, 32'hFFC};
      vecs[3] = '{2'b11, 32'h0, 32'h0, 3'b000, 3, 32'hFFD, 32'hFFE, 32'hFFF,
                  16'h0, 16'h0, 16'h0, 32'h0000_ABCD, 1'b1, 3'b101, 32'hFFF};
      vecs[4] = '{2'b00, 32'hDEAD_BEEF, 32'h1234_5678, 3'b010, 2, 32'hFFF, 32'hFFE, 32'h0,
                  16'hDEAD, 16'hBEEF, 16'h0, 32'h1234_5678, 1'b0, 3'b000, 32'hFFD};
      vecs[5] = '{2'b01, 32'h0, 32'h0, 3'b000, 2, 32'hFFE, 32'hFFF, 32'h0,
                  16'h0, 16'h0, 16'h0, 32'hDEAD_BEEF, 1'b0, 3'b000, 32'hFFF};

      rst_n = 1'b0;
      req_valid = 1'b0; req_op = 2'b00; req_pc = '0; req_target = '0; req_flags = '0;
      req_valid1 = 1'b0; req_op1 = 2'b00; req_pc1 = '0; req_target1 = '0; req_flags1 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sp", sp, 32'h0000_0FFF);
      chk("rst_count", 32'(count_out), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pc_out", pc_out, 32'h0);
      chk("rst_sp1", sp1, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         logic [31:0] ea[3];
         logic [15:0] ew[3];
         logic        push;
         ea[0] = vecs[i].a0; ea[1] = vecs[i].a1; ea[2] = vecs[i].a2;
         ew[0] = vecs[i].w0; ew[1] = vecs[i].w1; ew[2] = vecs[i].w2;
         push = (vecs[i].op == 2'b00) || (vecs[i].op == 2'b10);
         chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'd1);
         req_valid = 1'b1; req_op = vecs[i].op; req_pc = vecs[i].pc;
         req_target = vecs[i].target; req_flags = vecs[i].flags;
         @(negedge clk);
         req_valid = 1'b0;
         for (int k = 0; k < vecs[i].n; k++) begin
            chk($sformatf("v%0d_en%0d", i, k), 32'(mem_en), 32'd1);
            chk($sformatf("v%0d_we%0d", i, k), 32'(mem_we), 32'(push));
            chk($sformatf("v%0d_addr%0d", i, k), mem_addr, ea[k]);
            chk($sformatf("v%0d_cnt%0d", i, k), 32'(count_out), 32'(vecs[i].n - k));
            if (push) chk($sformatf("v%0d_wdata%0d", i, k), 32'(mem_wdata), 32'(ew[k]));
            @(negedge clk);
         end
         chk($sformatf("v%0d_drain_en", i), 32'(mem_en), 32'd0);
         chk($sformatf("v%0d_drain_done", i), 32'(done), 32'd0);
         chk($sformatf("v%0d_drain_busy", i), 32'(busy), 32'd1);
         @(negedge clk);
         chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
         chk($sformatf("v%0d_pc_out", i), pc_out, vecs[i].exp_pc);
         chk($sformatf("v%0d_fload", i), 32'(flags_load), 32'(vecs[i].exp_fload));
         chk($sformatf("v%0d_flags", i), 32'(flags_out), 32'(vecs[i].exp_flags));
         chk($sformatf("v%0d_sp", i), sp, vecs[i].exp_sp);
         chk($sformatf("v%0d_wdata_idle", i), 32'(mem_wdata), 32'd0);
         @(negedge clk);
         chk($sformatf("v%0d_done_low", i), 32'(done), 32'd0);
      end
      chk("done_total", 32'(done_cnt), 32'd6);

      // Reset in the middle of an INT aborts it without a done pulse.
      req_valid = 1'b1; req_op = 2'b10; req_pc = 32'h0000_1111;
      req_target = 32'h0000_0300; req_flags = 3'b011;
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort_cnt3", 32'(count_out), 32'd3);
      @(negedge clk);
      chk("abort_cnt2", 32'(count_out), 32'd2);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_ready", 32'(req_ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_sp", sp, 32'h0000_0FFF);
      chk("abort_count", 32'(count_out), 32'd0);
      chk("abort_mem_en", 32'(mem_en), 32'd0);
      repeat (8) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt), 32'd6);

      // Zero reset SP wraps downward; held req_valid is accepted once per idle.
      req_valid1 = 1'b1; req_op1 = 2'b00; req_pc1 = 32'h0001_2345; req_target1 = 32'h0000_0100;
      @(negedge clk);
      chk("wrap_addr0", mem_addr1, 32'h0000_0000);
      chk("wrap_wdata0", 32'(mem_wdata1), 32'h0001);
      @(negedge clk);
      chk("wrap_addr1", mem_addr1, 32'hFFFF_FFFF);
      chk("wrap_wdata1", 32'(mem_wdata1), 32'h2345);
      @(negedge clk);
      chk("wrap_drain_ready", 32'(req_ready1), 32'd0);
      @(negedge clk);
      chk("wrap_done", 32'(done1), 32'd1);
      chk("wrap_pc_out", pc_out1, 32'h0000_0100);
      chk("wrap_sp", sp1, 32'hFFFF_FFFE);
      chk("wrap_fload", 32'(flags_load1), 32'd0);
      @(negedge clk);
      chk("hold_idle_ready", 32'(req_ready1), 32'd1);
      @(negedge clk);
      chk("hold_reaccept_busy", 32'(busy1), 32'd1);
      chk("hold_reaccept_addr", mem_addr1, 32'hFFFF_FFFE);
      req_valid1 = 1'b0;
      repeat (6) @(negedge clk);
      chk("hold_done_count", 32'(done1_cnt), 32'd2);
      chk("hold_final_ready", 32'(req_ready1), 32'd1);
      chk("hold_final_sp", sp1, 32'hFFFF_FFFC);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
Multi-cycle stack sequencer for CALL, RET, INT and RTI in the pipelined processor. It accepts one control-flow request from decode and splits the 32-bit PC (and flags for INT/RTI) into 16-bit stack accesses, one per cycle, while owning the stack pointer. It stalls the front end until it returns the resolved PC. It also drives the remaining-access count consumed by the downstream countdown/continue machine.

Parameters:
ADDR_W, 32, stack pointer / memory address width
FLAG_W, 3, width of the CCR flag field
SP_RESET, 32'h0000_0FFF, stack pointer value after reset (truncated to ADDR_W)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  decode presents a stack request
req_op  in  2  00 CALL, 01 RET, 10 INT, 11 RTI
req_pc  in  32  return address to push (CALL/INT)
req_target  in  32  jump/vector target (CALL/INT)
req_flags  in  FLAG_W  current flags (INT)
req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
busy  out  1  high whenever state != IDLE (front-end stall)
mem_en  out  1  memory access this cycle
mem_we  out  1  1 = write (push), 0 = read (pop)
mem_addr  out  ADDR_W  stack address
mem_wdata  out  16  push data
mem_rdata  in  16  pop data, valid the cycle after the read access
sp  out  ADDR_W  current stack pointer
count_out  out  2  accesses remaining including the current one; 0 when idle
done  out  1  one-cycle completion pulse
pc_out  out  32  resolved PC, valid while done=1
flags_out  out  FLAG_W  restored flags, valid while flags_load=1
flags_load  out  1  pulses with done for RTI only

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, sp=SP_RESET, count=0; all outputs 0 except req_ready=1. Reset mid-sequence aborts with no done pulse; memory writes already issued stand.
- States: IDLE -> ACCESS -> DRAIN -> DONE -> IDLE.
- IDLE: on accept, latch op, pc, target, flags. Load count with N: CALL=2, RET=2, INT=3, RTI=3. Go to ACCESS.
- ACCESS: exactly one access per cycle, mem_en=1. count decrements each cycle. On count==1, go to DRAIN.
- Push (CALL/INT): mem_we=1, mem_addr=sp, sp<=sp-1 (post-decrement).
  - INT write order: flags zero-extended to 16 bits, then PC[31:16], then PC[15:0].
  - CALL write order: PC[31:16], then PC[15:0].
- Pop (RET/RTI): mem_we=0, mem_addr=sp+1, sp<=sp+1 (pre-increment).
  - Read order: PC[15:0], then PC[31:16], then (RTI only) flags.
  - mem_rdata is captured into the matching field in the cycle after each read.
- DRAIN: no access. Captures the final read data.
- DONE: done=1 for one cycle.
  - pc_out = latched target for CALL/INT; assembled popped PC for RET/RTI.
  - RTI only: flags_load=1, flags_out = popped word[FLAG_W-1:0].
- Latency: accept at edge t; accesses in cycles t+1..t+N; DRAIN at t+N+1; done at t+N+2; req_ready high again at t+N+3.
- req_valid while not ready is ignored (not queued). req_valid held through DONE is accepted at the first IDLE cycle.
- sp arithmetic is modulo 2^ADDR_W (wraps silently); no overflow or underflow detection.
- mem_wdata = 0 and mem_addr = sp whenever mem_en=0.

Test Plan:
- CALL req_pc=0x00012345, req_target=0x00000100, sp=0x0FFF -> write 0x0001@0x0FFF, then 0x2345@0x0FFE; count_out 2,1; sp=0x0FFD; done at t+4 with pc_out=0x00000100; flags_load=0.
- RET directly after that CALL, memory model returning the written data -> reads @0x0FFE then @0x0FFF; pc_out=0x00012345; sp=0x0FFF.
- INT req_flags=3'b101, req_pc=0x0000ABCD -> writes 0x0005, 0x0000, 0xABCD at 0x0FFF..0x0FFD; done at t+5.
- Follow with RTI -> pc_out=0x0000ABCD, flags_load=1, flags_out=3'b101, sp=0x0FFF.
- INT accepted, rst_n=0 at its second access cycle -> next cycle state IDLE, sp=SP_RESET, count_out=0; no done pulse ever.
- SP_RESET=0, CALL -> writes at 0x00000000 then 0xFFFFFFFF; sp=0xFFFFFFFE. req_valid held high throughout is accepted only once busy drops (one done per accepted request).
